// File: rtl/twos_comp_seq_ctrl.sv
// twos_comp_seq_ctrl
// Sequencer for an external bit-serial two's-complement negator (i/r/y cell).
// It takes a parallel word, shifts it out LSB-first on ser_i and marks the
// first bit with ser_r. It collects ser_y back into a parallel result and
// reports completion and most-negative overflow.
//
// Ports:
//   t_clk  in   rising-edge clock
//   rn     in   asynchronous active-low reset
//   start  in   request; accepted only while ready=1
//   din    in   WIDTH operand, sampled on the accepting edge
//   ready  out  high only in IDLE
//   done   out  one-cycle pulse when dout becomes valid
//   dout   out  WIDTH negated result, held until the next word's done
//   ovf    out  operand was the most-negative value; valid with done, held
//   ser_i  out  serial operand bit to the negator i input
//   ser_r  out  word-start/clear strobe to the negator r input
//   ser_y  in   negator y output, sampled at the end of each bit cycle
module twos_comp_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             t_clk,
  input  logic             rn,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             ser_i,
  output logic             ser_r,
  input  logic             ser_y
);

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sreg,  w_sreg;
  logic [WIDTH-1:0] r_res,   w_res;
  logic [CNT_W-1:0] r_cnt,   w_cnt;
  logic             r_ovf_nx, w_ovf_nx;
  logic             r_ready, w_ready;
  logic             r_done,  w_done;
  logic [WIDTH-1:0] r_dout,  w_dout;
  logic             r_ovf,   w_ovf;
  logic             r_ser_i, w_ser_i;
  logic             r_ser_r, w_ser_r;

  // State and output registers; reset parks the negator in its clear condition
  always_ff @(posedge t_clk or negedge rn) begin
    if (!rn) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_ovf_nx <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_dout   <= '0;
      r_ovf    <= 1'b0;
      r_ser_i  <= 1'b0;
      r_ser_r  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_sreg   <= w_sreg;
      r_res    <= w_res;
      r_cnt    <= w_cnt;
      r_ovf_nx <= w_ovf_nx;
      r_ready  <= w_ready;
      r_done   <= w_done;
      r_dout   <= w_dout;
      r_ovf    <= w_ovf;
      r_ser_i  <= w_ser_i;
      r_ser_r  <= w_ser_r;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state  = r_state;
    w_sreg   = r_sreg;
    w_res    = r_res;
    w_cnt    = r_cnt;
    w_ovf_nx = r_ovf_nx;
    w_ready  = r_ready;
    w_done   = 1'b0;
    w_dout   = r_dout;
    w_ovf    = r_ovf;
    w_ser_i  = r_ser_i;
    w_ser_r  = r_ser_r;

    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_ser_i = 1'b0;
        w_ser_r = 1'b1;
        if (start) begin
          // Bit 0 goes out with r=1 so the negator starts from a clear flag
          w_sreg   = din;
          w_res    = '0;
          w_ovf_nx = (din == C_MOST_NEG);
          w_cnt    = '0;
          w_ser_i  = din[0];
          w_ser_r  = 1'b1;
          w_ready  = 1'b0;
          w_state  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_ready = 1'b0;
        w_res   = {ser_y, r_res[WIDTH-1:1]};
        w_sreg  = r_sreg >> 1;
        w_cnt   = r_cnt + CNT_W'(1);
        if (r_cnt == C_LAST_BIT) begin
          // Last bit captured: publish the result and return the negator to clear
          w_ser_i = 1'b0;
          w_ser_r = 1'b1;
          w_done  = 1'b1;
          w_dout  = w_res;
          w_ovf   = r_ovf_nx;
          w_state = S_DONE;
        end else begin
          w_ser_i = r_sreg[1];
          w_ser_r = 1'b0;
        end
      end

      S_DONE: begin
        // start is ignored here; IDLE follows unconditionally
        w_ready = 1'b1;
        w_state = S_IDLE;
      end

      default: begin
        w_ready = 1'b1;
        w_ser_i = 1'b0;
        w_ser_r = 1'b1;
        w_state = S_IDLE;
      end
    endcase
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign dout  = r_dout;
  assign ovf   = r_ovf;
  assign ser_i = r_ser_i;
  assign ser_r = r_ser_r;

endmodule

// File: tb/tb_twos_comp_seq_ctrl.sv
// Bench for twos_comp_seq_ctrl: external negator model, directed table,
// multi-cycle corner sequences and randomized words against -x mod 2^8.
module tb_twos_comp_seq_ctrl;

  localparam int unsigned W = 8;

  logic         t_clk = 1'b0;
  logic         rn;
  logic         start;
  logic [W-1:0] din;
  logic         ready;
  logic         done;
  logic [W-1:0] dout;
  logic         ovf;
  logic         ser_i;
  logic         ser_r;
  logic         ser_y;

  int n_vec = 0;
  int n_err = 0;

  twos_comp_seq_ctrl #(.WIDTH(W)) dut (
    .t_clk (t_clk),
    .rn    (rn),
    .start (start),
    .din   (din),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .ovf   (ovf),
    .ser_i (ser_i),
    .ser_r (ser_r),
    .ser_y (ser_y)
  );

  always #5 t_clk = ~t_clk;

  // External serial negator: y = i ^ (Q & ~r); Q' = i | (Q & ~r)
  logic q = 1'b0;
  always @(posedge t_clk) q <= ser_i | (q & ~ser_r);
  assign ser_y = ser_i ^ (q & ~ser_r);

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for IDLE, launch one word and check every cycle up to IDLE again
  task automatic do_word(input logic [W-1:0] d, input logic [W-1:0] exp_d,
                         input logic exp_o, input bit scramble);
    int t;
    t = 0;
    while (!ready && t < 20) begin
      @(negedge t_clk);
      t++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    start = 1'b1;
    din   = d;
    @(negedge t_clk);
    start = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      chk("ser_i", 32'(ser_i), 32'(d[k]));
      chk("ser_r", 32'(ser_r), 32'(k == 0));
      chk("busy_ready", 32'(ready), 32'd0);
      chk("early_done", 32'(done), 32'd0);
      if (scramble) din = W'($urandom);
      @(negedge t_clk);
    end
    chk("done", 32'(done), 32'd1);
    chk("dout", 32'(dout), 32'(exp_d));
    chk("ovf", 32'(ovf), 32'(exp_o));
    chk("done_ready", 32'(ready), 32'd0);
    @(negedge t_clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_ser_r", 32'(ser_r), 32'd1);
    chk("held_dout", 32'(dout), 32'(exp_d));
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [W-1:0] re;

    tbl[0] = '{din: 8'h01, dout: 8'hFF, ovf: 1'b0};
    tbl[1] = '{din: 8'h06, dout: 8'hFA, ovf: 1'b0};
    tbl[2] = '{din: 8'h00, dout: 8'h00, ovf: 1'b0};
    tbl[3] = '{din: 8'hFF, dout: 8'h01, ovf: 1'b0};
    tbl[4] = '{din: 8'h80, dout: 8'h80, ovf: 1'b1};
    tbl[5] = '{din: 8'h7F, dout: 8'h81, ovf: 1'b0};

    rn = 1'b0;
    start = 1'b0;
    din = '0;
    repeat (3) @(negedge t_clk);
    rn = 1'b1;
    @(negedge t_clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ser_i", 32'(ser_i), 32'd0);
    chk("rst_ser_r", 32'(ser_r), 32'd1);

    // Directed table; 0x80 then 0x7F checks the flag clears between words
    for (int v = 0; v < 6; v++)
      do_word(tbl[v].din, tbl[v].dout, tbl[v].ovf, 1'b0);

    // start held high: one accept per W+2 cycles, start ignored while busy
    while (!ready) @(negedge t_clk);
    start = 1'b1;
    din = 8'h03;
    for (int j = 1; j <= 30; j++) begin
      @(negedge t_clk);
      if (j == 30) start = 1'b0;
      chk("hold_ready", 32'(ready), 32'(j % 10 == 0));
      chk("hold_done", 32'(done), 32'(j % 10 == 9));
      if (j >= 9) chk("hold_dout", 32'(dout), 32'h0000_00FD);
    end

    // Reset during bit 4 of 0x10 (dout holds 0xFD beforehand)
    start = 1'b1;
    din = 8'h10;
    @(negedge t_clk);
    start = 1'b0;
    repeat (4) @(negedge t_clk);
    chk("pre_rst_bit4", 32'(ser_i), 32'd1);
    #2 rn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ser_r", 32'(ser_r), 32'd1);
    chk("mid_rst_ser_i", 32'(ser_i), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge t_clk);
    rn = 1'b1;
    @(negedge t_clk);
    do_word(8'h01, 8'hFF, 1'b0, 1'b0);

    // din changes every busy cycle
    do_word(8'h5A, 8'hA6, 1'b0, 1'b1);

    // Random words against arithmetic negation
    for (int r = 0; r < 40; r++) begin
      rd = W'($urandom);
      if (r == 7) rd = 8'h80;
      re = W'(9'd256 - 9'(rd));
      do_word(rd, re, rd == 8'h80, (r % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
